// File: rtl/fetch_controller.sv
// fetch_controller
// ----------------
// Instruction-fetch sequencer for the 16-bit pipeline. Owns the program
// counter, drives the read address of a one-cycle-latency instruction
// memory and fills the IF/ID register with instruction, PC and valid flag.
// Honours stall and branch redirect, and stops fetching after a HALT word.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   rst          in   synchronous active-high reset (overrides everything)
//   stall        in   hold IF/ID and PC this cycle
//   redirect     in   branch/jump taken: flush, restart at redirect_pc
//   redirect_pc  in   redirect target address
//   mem_addr     out  instruction memory read address (combinational)
//   mem_inst     in   memory data for the previous cycle's mem_addr
//   if_inst      out  IF/ID instruction (registered)
//   if_pc        out  PC of if_inst (registered)
//   if_valid     out  if_inst is a real instruction
//   halted       out  high while in HALTED state
//   fetch_count  out  valid instructions delivered, wraps at 2^16
//   state_dbg    out  current FSM state (0 = FETCH, 1 = HALTED)
//
// Handshake: there is no ready/valid back-pressure; stall is the only flow
// control. if_valid qualifies if_inst/if_pc in every cycle it is high, and
// while stall is high the consumer sees the same if_* values repeated.
module fetch_controller #(
    parameter int unsigned          ADDR_W    = 10,
    parameter int unsigned          INST_W    = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter logic [INST_W-1:0]    HALT_INST = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_inst,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              halted,
    output logic [15:0]       fetch_count,
    output logic              state_dbg
);

    typedef enum logic {
        S_FETCH  = 1'b0,
        S_HALTED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;   // address of word arriving on mem_inst
    logic              fv_q, fv_d;     // that word is worth delivering
    logic [INST_W-1:0] if_inst_q, if_inst_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic              if_valid_q, if_valid_d;
    logic [15:0]       count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            fpc_q      <= '0;
            fv_q       <= 1'b0;
            if_inst_q  <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fpc_q      <= fpc_d;
            fv_q       <= fv_d;
            if_inst_q  <= if_inst_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fpc_d      = fpc_q;
        fv_d       = fv_q;
        if_inst_d  = if_inst_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        count_d    = count_q;
        mem_addr   = pc_q;

        if (redirect) begin
            // Target is issued this cycle, so it becomes the in-flight word.
            mem_addr   = redirect_pc;
            if_valid_d = 1'b0;
            fpc_d      = redirect_pc;
            fv_d       = 1'b1;
            pc_d       = redirect_pc + ADDR_W'(1);
            state_d    = S_FETCH;
        end else if (state_q == S_HALTED) begin
            // Stall is irrelevant here; nothing is fetched.
            if_valid_d = 1'b0;
        end else if (stall) begin
            // Re-read the in-flight word so it is still on mem_inst next cycle.
            mem_addr = fpc_q;
        end else begin
            if_inst_d  = mem_inst;
            if_pc_d    = fpc_q;
            if_valid_d = fv_q;
            fpc_d      = pc_q;
            fv_d       = 1'b1;
            pc_d       = pc_q + ADDR_W'(1);
            if (fv_q) begin
                count_d = count_q + 16'd1;
                if (mem_inst == HALT_INST) begin
                    // Deliver the HALT itself, squash the word issued behind it.
                    fv_d    = 1'b0;
                    pc_d    = pc_q;
                    state_d = S_HALTED;
                end
            end
        end
    end

    assign if_inst     = if_inst_q;
    assign if_pc       = if_pc_q;
    assign if_valid    = if_valid_q;
    assign halted      = (state_q == S_HALTED);
    assign fetch_count = count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst0 = 1'b1;
    logic        rst1 = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [9:0]  redirect_pc = '0;

    logic [9:0]  mem_addr0, mem_addr1;
    logic [15:0] mem_inst0, mem_inst1;
    logic [15:0] if_inst0, if_inst1;
    logic [9:0]  if_pc0, if_pc1;
    logic        if_valid0, if_valid1;
    logic        halted0, halted1;
    logic [15:0] fetch_count0, fetch_count1;
    logic        state_dbg0, state_dbg1;

    logic [15:0] mem0 [0:1023];
    logic [15:0] mem1 [0:1023];

    int checks = 0;
    int errors = 0;

    // clock / reset block
    always #5 clk = ~clk;

    // one-cycle-latency instruction memories
    always @(posedge clk) mem_inst0 <= mem0[mem_addr0];
    always @(posedge clk) mem_inst1 <= mem1[mem_addr1];

    fetch_controller #(.ADDR_W(10), .INST_W(16), .RESET_PC(10'd0), .HALT_INST(16'hFFFF)) dut0 (
        .clk(clk), .rst(rst0), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_addr(mem_addr0), .mem_inst(mem_inst0), .if_inst(if_inst0), .if_pc(if_pc0),
        .if_valid(if_valid0), .halted(halted0), .fetch_count(fetch_count0), .state_dbg(state_dbg0)
    );

    fetch_controller #(.ADDR_W(10), .INST_W(16), .RESET_PC(10'd1022), .HALT_INST(16'hFFFF)) dut1 (
        .clk(clk), .rst(rst1), .stall(1'b0), .redirect(1'b0), .redirect_pc(10'd0),
        .mem_addr(mem_addr1), .mem_inst(mem_inst1), .if_inst(if_inst1), .if_pc(if_pc1),
        .if_valid(if_valid1), .halted(halted1), .fetch_count(fetch_count1), .state_dbg(state_dbg1)
    );

    // advance one edge and sample away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; stall = 1'b0; redirect = 1'b0;
        tick(); tick();
        checks++;
        if (if_valid0 !== 1'b0 || if_pc0 !== 10'd0 || if_inst0 !== 16'h0) begin
            errors++; $display("FAIL reset_ifid: valid=%b pc=%0d inst=%h expected 0/0/0", if_valid0, if_pc0, if_inst0);
        end
        checks++;
        if (halted0 !== 1'b0 || fetch_count0 !== 16'd0 || state_dbg0 !== 1'b0) begin
            errors++; $display("FAIL reset_state: halted=%b count=%0d state=%b expected 0/0/0", halted0, fetch_count0, state_dbg0);
        end
        checks++;
        if (mem_addr0 !== 10'd0) begin
            errors++; $display("FAIL reset_addr: got %0d expected 0", mem_addr0);
        end
    endtask

    task automatic test_run();
        rst0 = 1'b0;
        tick(); // edge 0
        checks++;
        if (if_valid0 !== 1'b0) begin
            errors++; $display("FAIL run_edge0_valid: got %b expected 0", if_valid0);
        end
        tick(); // edge 1
        checks++;
        if (if_valid0 !== 1'b1 || if_pc0 !== 10'd0 || if_inst0 !== 16'h1111 || fetch_count0 !== 16'd1) begin
            errors++; $display("FAIL run_first: valid=%b pc=%0d inst=%h cnt=%0d expected 1/0/1111/1", if_valid0, if_pc0, if_inst0, fetch_count0);
        end
        tick();
        checks++;
        if (if_valid0 !== 1'b1 || if_pc0 !== 10'd1 || if_inst0 !== 16'h2222 || fetch_count0 !== 16'd2) begin
            errors++; $display("FAIL run_second: valid=%b pc=%0d inst=%h cnt=%0d expected 1/1/2222/2", if_valid0, if_pc0, if_inst0, fetch_count0);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        checks++;
        if (mem_addr0 !== 10'd2) begin
            errors++; $display("FAIL stall_addr: got %0d expected 2", mem_addr0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (if_valid0 !== 1'b1 || if_pc0 !== 10'd1 || if_inst0 !== 16'h2222 || fetch_count0 !== 16'd2) begin
                errors++; $display("FAIL stall_hold%0d: valid=%b pc=%0d inst=%h cnt=%0d expected 1/1/2222/2", i, if_valid0, if_pc0, if_inst0, fetch_count0);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (if_valid0 !== 1'b1 || if_pc0 !== 10'd2 || if_inst0 !== 16'h3333 || fetch_count0 !== 16'd3) begin
            errors++; $display("FAIL stall_resume: valid=%b pc=%0d inst=%h cnt=%0d expected 1/2/3333/3", if_valid0, if_pc0, if_inst0, fetch_count0);
        end
        tick();
        checks++;
        if (if_pc0 !== 10'd3 || if_inst0 !== 16'h4444) begin
            errors++; $display("FAIL stall_next: pc=%0d inst=%h expected 3/4444", if_pc0, if_inst0);
        end
        tick(); tick(); // pc4, pc5
        checks++;
        if (if_valid0 !== 1'b1 || if_pc0 !== 10'd5 || if_inst0 !== 16'hA005 || fetch_count0 !== 16'd6) begin
            errors++; $display("FAIL stream_pc5: valid=%b pc=%0d inst=%h cnt=%0d expected 1/5/a005/6", if_valid0, if_pc0, if_inst0, fetch_count0);
        end
    endtask

    // redirect from the current stream; old_pc is the if_pc on entry
    task automatic do_redirect(input logic [9:0] target, input logic with_stall,
                               input logic [9:0] old_pc, input logic [15:0] cnt0, input string tag);
        redirect = 1'b1; redirect_pc = target; stall = with_stall;
        #1;
        checks++;
        if (mem_addr0 !== target) begin
            errors++; $display("FAIL %s_addr: got %h expected %h", tag, mem_addr0, target);
        end
        tick();
        redirect = 1'b0; stall = 1'b0;
        checks++;
        if (if_valid0 !== 1'b0 || if_pc0 !== old_pc || fetch_count0 !== cnt0) begin
            errors++; $display("FAIL %s_bubble: valid=%b pc=%h cnt=%0d expected 0/%h/%0d", tag, if_valid0, if_pc0, fetch_count0, old_pc, cnt0);
        end
        tick();
        checks++;
        if (if_valid0 !== 1'b1 || if_pc0 !== target || if_inst0 !== (16'hA000 | {6'd0, target}) || fetch_count0 !== cnt0 + 16'd1) begin
            errors++; $display("FAIL %s_target: valid=%b pc=%h inst=%h cnt=%0d expected 1/%h/%h/%0d", tag, if_valid0, if_pc0, if_inst0, fetch_count0, target, 16'hA000 | {6'd0, target}, cnt0 + 16'd1);
        end
        tick();
        checks++;
        if (if_valid0 !== 1'b1 || if_pc0 !== target + 10'd1) begin
            errors++; $display("FAIL %s_seq: valid=%b pc=%h expected 1/%h", tag, if_valid0, if_pc0, target + 10'd1);
        end
    endtask

    task automatic test_redirect();
        do_redirect(10'h200, 1'b0, 10'd5, 16'd6, "redirect");
    endtask

    task automatic test_redirect_stall();
        do_redirect(10'h300, 1'b1, 10'h201, 16'd8, "redir_stall");
    endtask

    task automatic test_halt();
        mem0[4] = 16'hFFFF;
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        tick(); // edge 0
        for (int i = 0; i < 5; i++) tick(); // edges 1..5 deliver pc0..pc4
        checks++;
        if (if_valid0 !== 1'b1 || if_pc0 !== 10'd4 || if_inst0 !== 16'hFFFF || fetch_count0 !== 16'd5) begin
            errors++; $display("FAIL halt_deliver: valid=%b pc=%0d inst=%h cnt=%0d expected 1/4/ffff/5", if_valid0, if_pc0, if_inst0, fetch_count0);
        end
        for (int i = 0; i < 12; i++) begin
            stall = (i >= 6 && i < 9);
            tick();
            checks++;
            if (if_valid0 !== 1'b0 || halted0 !== 1'b1 || fetch_count0 !== 16'd5 || mem_addr0 !== 10'd5) begin
                errors++; $display("FAIL halt_hold%0d: valid=%b halted=%b cnt=%0d addr=%0d expected 0/1/5/5", i, if_valid0, halted0, fetch_count0, mem_addr0);
            end
        end
        stall = 1'b0;
        redirect = 1'b1; redirect_pc = 10'd0;
        tick();
        redirect = 1'b0;
        checks++;
        if (halted0 !== 1'b0 || if_valid0 !== 1'b0) begin
            errors++; $display("FAIL halt_release: halted=%b valid=%b expected 0/0", halted0, if_valid0);
        end
        tick();
        checks++;
        if (if_valid0 !== 1'b1 || if_pc0 !== 10'd0 || if_inst0 !== 16'h1111 || fetch_count0 !== 16'd6) begin
            errors++; $display("FAIL halt_resume: valid=%b pc=%0d inst=%h cnt=%0d expected 1/0/1111/6", if_valid0, if_pc0, if_inst0, fetch_count0);
        end
        tick();
        checks++;
        if (if_pc0 !== 10'd1 || if_inst0 !== 16'h2222) begin
            errors++; $display("FAIL halt_resume2: pc=%0d inst=%h expected 1/2222", if_pc0, if_inst0);
        end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_pc [0:3];
        exp_pc[0] = 10'd1022; exp_pc[1] = 10'd1023; exp_pc[2] = 10'd0; exp_pc[3] = 10'd1;
        rst1 = 1'b1; tick(); tick(); rst1 = 1'b0;
        tick(); // edge 0
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (if_valid1 !== 1'b1 || if_pc1 !== exp_pc[i] || if_inst1 !== (16'hB000 | {6'd0, exp_pc[i]})) begin
                errors++; $display("FAIL wrap_%0d: valid=%b pc=%0d inst=%h expected 1/%0d/%h", i, if_valid1, if_pc1, if_inst1, exp_pc[i], 16'hB000 | {6'd0, exp_pc[i]});
            end
        end
        checks++;
        if (fetch_count1 !== 16'd4) begin
            errors++; $display("FAIL wrap_count: got %0d expected 4", fetch_count1);
        end
    endtask

    task automatic test_reset_mid();
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        checks++;
        if (if_valid1 !== 1'b0 || fetch_count1 !== 16'd0 || if_pc1 !== 10'd0 || if_inst1 !== 16'h0) begin
            errors++; $display("FAIL midrst: valid=%b cnt=%0d pc=%0d inst=%h expected 0/0/0/0", if_valid1, fetch_count1, if_pc1, if_inst1);
        end
        tick();
        checks++;
        if (if_valid1 !== 1'b0) begin
            errors++; $display("FAIL midrst_discard: valid=%b expected 0", if_valid1);
        end
        tick();
        checks++;
        if (if_valid1 !== 1'b1 || if_pc1 !== 10'd1022 || fetch_count1 !== 16'd1) begin
            errors++; $display("FAIL midrst_restart: valid=%b pc=%0d cnt=%0d expected 1/1022/1", if_valid1, if_pc1, fetch_count1);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = 16'hA000 | 16'(i);
            mem1[i] = 16'hB000 | 16'(i);
        end
        mem0[0] = 16'h1111; mem0[1] = 16'h2222; mem0[2] = 16'h3333; mem0[3] = 16'h4444;
        #2;
        test_reset();
        test_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
